// File: rtl/cr_kme_fifo_wr_pack.sv
// Write-side packer for the KME 96-bit staging FIFOs.
// Collects BEATS narrow beats (or fewer when in_last closes a word early)
// into one wide word and presents it to the FIFO write port, holding it
// while the FIFO stalls so the FIFO never sees a write it cannot take.
module cr_kme_fifo_wr_pack #(
    parameter int BEAT_W = 32,
    parameter int BEATS  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BEAT_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [BEAT_W*BEATS-1:0] fifo_in,
    output logic                    fifo_in_valid,
    input  logic                    fifo_in_stall,
    input  logic                    fifo_overflow,
    output logic [CNT_W-1:0]        words_sent,
    output logic                    sticky_overflow,
    output logic                    idle
);

    localparam int WORD_W = BEAT_W * BEATS;
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] out_data;
    logic [WORD_W-1:0] merged;
    logic [IDX_W-1:0]  idx;
    logic              out_vld;
    logic              drain;
    logic              accept;
    logic              word_done;

    // A pending word leaves whenever the FIFO is not stalled; a beat can be
    // taken whenever the output register is empty or emptying this cycle,
    // which lets drain and load overlap with no bubble.
    assign drain         = out_vld & ~fifo_in_stall;
    assign in_ready      = ~out_vld | drain;
    assign accept        = in_valid & in_ready;
    assign word_done     = (idx == LAST_IDX) | in_last;
    assign fifo_in_valid = drain;
    assign fifo_in       = out_data;
    assign idle          = (idx == '0) & ~out_vld;

    // Current accumulator with the incoming beat dropped into its slot.
    always_comb begin
        merged = acc;
        merged[idx*BEAT_W +: BEAT_W] = in_data;
    end

    // Accumulator and beat index: fill beat by beat, restart on completion.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            if (word_done) begin
                acc <= '0;
                idx <= '0;
            end else begin
                acc <= merged;
                idx <= idx + 1'b1;
            end
        end
    end

    // Output register: load a completed word, otherwise clear valid on drain.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_data <= '0;
            out_vld  <= 1'b0;
        end else if (accept && word_done) begin
            out_data <= merged;
            out_vld  <= 1'b1;
        end else if (drain) begin
            out_vld  <= 1'b0;
        end
    end

    // Count of words handed to the FIFO; wraps naturally.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            words_sent <= '0;
        end else if (drain) begin
            words_sent <= words_sent + 1'b1;
        end
    end

    // Latch any FIFO overflow until the next reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sticky_overflow <= 1'b0;
        end else if (fifo_overflow) begin
            sticky_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cr_kme_fifo_wr_pack.sv
// Self-checking bench for cr_kme_fifo_wr_pack: directed scenarios with
// literal expectations plus a queue-based reference model checked every cycle.
module tb_cr_kme_fifo_wr_pack;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [95:0] fifo_in;
    logic        fifo_in_valid;
    logic        fifo_in_stall;
    logic        fifo_overflow;
    logic [15:0] words_sent;
    logic        sticky_overflow;
    logic        idle;

    int compared   = 0;
    int mismatched = 0;

    cr_kme_fifo_wr_pack #(.BEAT_W(32), .BEATS(3), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .fifo_in        (fifo_in),
        .fifo_in_valid  (fifo_in_valid),
        .fifo_in_stall  (fifo_in_stall),
        .fifo_overflow  (fifo_overflow),
        .words_sent     (words_sent),
        .sticky_overflow(sticky_overflow),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by the directed checks and the model.
    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic v, input logic l, input logic s);
        in_data       = d;
        in_valid      = v;
        in_last       = l;
        fifo_in_stall = s;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        repeat (2) cyc();
        rst_n = 1'b0;
    endtask

    // Reference model: beats collected into words, completed-but-unwritten
    // words queued in order. Checked at each falling edge, then advanced to
    // the state the next rising edge must produce.
    logic [31:0] part_q[$];
    logic [95:0] pend_q[$];
    logic [15:0] m_sent;
    bit          m_sticky;

    initial begin
        bit          m_ready;
        bit          m_drain;
        logic [95:0] w;
        m_sent   = '0;
        m_sticky = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                part_q.delete();
                pend_q.delete();
                m_sent   = '0;
                m_sticky = 1'b0;
            end else begin
                m_ready = (pend_q.size() == 0) || !fifo_in_stall;
                m_drain = (pend_q.size() != 0) && !fifo_in_stall;
                checkOutput("m_in_ready", {95'b0, in_ready}, {95'b0, m_ready});
                checkOutput("m_fifo_in_valid", {95'b0, fifo_in_valid}, {95'b0, m_drain});
                checkOutput("m_no_write_on_stall", {95'b0, fifo_in_valid & fifo_in_stall}, 96'b0);
                if (pend_q.size() != 0)
                    checkOutput("m_fifo_in", fifo_in, pend_q[0]);
                checkOutput("m_words_sent", {80'b0, words_sent}, {80'b0, m_sent});
                checkOutput("m_idle", {95'b0, idle},
                            {95'b0, (part_q.size() == 0) && (pend_q.size() == 0)});
                checkOutput("m_sticky", {95'b0, sticky_overflow}, {95'b0, m_sticky});
                if (m_drain) begin
                    void'(pend_q.pop_front());
                    m_sent = m_sent + 16'd1;
                end
                if (in_valid && m_ready) begin
                    part_q.push_back(in_data);
                    if (part_q.size() == 3 || in_last) begin
                        w = '0;
                        for (int j = 0; j < part_q.size(); j++)
                            w[j*32 +: 32] = part_q[j];
                        pend_q.push_back(w);
                        part_q.delete();
                    end
                end
                if (fifo_overflow) m_sticky = 1'b1;
            end
        end
    end

    initial begin
        int i;
        int budget;
        bit rdy;
        rst_n         = 1'b1;
        fifo_overflow = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc();

        // Reset values
        @(negedge clk);
        checkOutput("rst_in_ready", {95'b0, in_ready}, 96'd1);
        checkOutput("rst_fifo_in_valid", {95'b0, fifo_in_valid}, 96'd0);
        checkOutput("rst_fifo_in", fifo_in, 96'd0);
        checkOutput("rst_words_sent", {80'b0, words_sent}, 96'd0);
        checkOutput("rst_sticky", {95'b0, sticky_overflow}, 96'd0);
        checkOutput("rst_idle", {95'b0, idle}, 96'd1);
        cyc();
        rst_n = 1'b0;
        // Junk on data/last while not valid must be ignored
        applyStimulus(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc();

        // Full word, back-to-back beats
        applyStimulus(32'h11111111, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'h22222222, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'h33333333, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full_valid", {95'b0, fifo_in_valid}, 96'd1);
        checkOutput("full_word", fifo_in, 96'h333333332222222211111111);
        cyc();
        @(negedge clk);
        checkOutput("full_valid_off", {95'b0, fifo_in_valid}, 96'd0);
        checkOutput("full_count", {80'b0, words_sent}, 96'd1);
        checkOutput("full_idle", {95'b0, idle}, 96'd1);

        // Partial flush at idx 1
        cyc();
        applyStimulus(32'hBBBB0000, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'hAAAA0001, 1'b1, 1'b1, 1'b0); cyc();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("partial_valid", {95'b0, fifo_in_valid}, 96'd1);
        checkOutput("partial_word", fifo_in, 96'h00000000AAAA0001BBBB0000);
        cyc();

        // Single-beat word via in_last at idx 0
        applyStimulus(32'h00C0FFEE, 1'b1, 1'b1, 1'b0); cyc();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_word", fifo_in, 96'h00000000000000000000C0FFEE);
        cyc();

        // Stall hold
        applyStimulus(32'hA0A0A0A0, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'hA1A1A1A1, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'hA2A2A2A2, 1'b1, 1'b0, 1'b1); cyc();
        applyStimulus(32'hB0B0B0B0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("hold_ready", {95'b0, in_ready}, 96'd0);
            checkOutput("hold_valid", {95'b0, fifo_in_valid}, 96'd0);
            checkOutput("hold_word", fifo_in, 96'hA2A2A2A2A1A1A1A1A0A0A0A0);
            cyc();
        end
        fifo_in_stall = 1'b0;
        @(negedge clk);
        checkOutput("release_valid", {95'b0, fifo_in_valid}, 96'd1);
        checkOutput("release_word", fifo_in, 96'hA2A2A2A2A1A1A1A1A0A0A0A0);
        checkOutput("release_ready", {95'b0, in_ready}, 96'd1);
        cyc();
        applyStimulus(32'hB1B1B1B1, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'hB2B2B2B2, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("after_hold_word", fifo_in, 96'hB2B2B2B2B1B1B1B1B0B0B0B0);
        cyc();

        // Overflow latch
        fifo_overflow = 1'b1;
        @(negedge clk);
        checkOutput("ovf_not_yet", {95'b0, sticky_overflow}, 96'd0);
        cyc();
        fifo_overflow = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        checkOutput("ovf_sticky", {95'b0, sticky_overflow}, 96'd1);

        // Reset mid-word discards the partial word
        cyc();
        applyStimulus(32'hE0E0E0E0, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'hE1E1E1E1, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        do_reset();
        @(negedge clk);
        checkOutput("midrst_idle", {95'b0, idle}, 96'd1);
        checkOutput("midrst_valid", {95'b0, fifo_in_valid}, 96'd0);
        checkOutput("midrst_sticky", {95'b0, sticky_overflow}, 96'd0);
        cyc();
        applyStimulus(32'hF0F0F0F0, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'hF1F1F1F1, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'hF2F2F2F2, 1'b1, 1'b0, 1'b0); cyc();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_word", fifo_in, 96'hF2F2F2F2F1F1F1F1F0F0F0F0);
        checkOutput("midrst_wvalid", {95'b0, fifo_in_valid}, 96'd1);

        // Streaming 300 beats with random stall
        do_reset();
        cyc();
        i      = 0;
        budget = 3000;
        while (i < 300 && budget > 0) begin
            applyStimulus(32'hC0000000 + i, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            @(negedge clk);
            rdy = in_ready;
            cyc();
            if (rdy) i++;
            budget--;
        end
        if (budget == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL stream_timeout: got %0d beats expected 300", i);
        end
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        repeat (4) cyc();
        @(negedge clk);
        checkOutput("stream_count", {80'b0, words_sent}, 96'd100);
        checkOutput("stream_idle", {95'b0, idle}, 96'd1);

        // Counter wrap: 65536 single-beat words
        do_reset();
        cyc();
        for (int k = 0; k < 65536; k++) begin
            applyStimulus(k[31:0], 1'b1, 1'b1, 1'b0);
            cyc();
        end
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("wrap_pre", {80'b0, words_sent}, 96'd65535);
        checkOutput("wrap_last_word", fifo_in, 96'h0000000000000000_0000FFFF);
        cyc();
        @(negedge clk);
        checkOutput("wrap_zero", {80'b0, words_sent}, 96'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cr_kme_fifo_wr_pack.md
# cr_kme_fifo_wr_pack

Write-side packer for the KME 96-bit staging FIFOs. Accepts a stream of 32-bit beats with valid/ready, packs three beats into one 96-bit word, and drives the FIFO write port (`fifo_in`, `fifo_in_valid`), honouring the FIFO's `fifo_in_stall`. It sits between a narrow KME producer and the FIFO, so the FIFO itself never sees a write while stalled. It also reports a write count and a sticky overflow flag.

## Interface
- `BEAT_W`, default 32, input beat width.
- `BEATS`, default 3, beats per output word; output width is `BEAT_W*BEATS` (96).
- `CNT_W`, default 16, width of `words_sent`.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-high reset: state clears while `rst_n`==1. The port keeps the codebase name; polarity and synchronicity are fixed as stated.
- `in_data`  in  BEAT_W  beat payload.
- `in_valid`  in  1  beat present.
- `in_last`  in  1  beat closes the current word early; qualified by `in_valid`.
- `in_ready`  out  1  packer accepts a beat this cycle.
- `fifo_in`  out  BEAT_W*BEATS  write data to the FIFO.
- `fifo_in_valid`  out  1  write enable to the FIFO, one word per high cycle.
- `fifo_in_stall`  in  1  FIFO has no free slot or is overridden.
- `fifo_overflow`  in  1  FIFO overflow indication.
- `words_sent`  out  CNT_W  count of FIFO writes; wraps.
- `sticky_overflow`  out  1  latched `fifo_overflow`.
- `idle`  out  1  no partial word and no pending word.

## Operation
- **State:**
  - accumulator `acc` (BEAT_W*BEATS);
  - beat index `idx` (0..BEATS-1);
  - output register `out_data` plus `out_vld`.
- **Beat accept:** accept = `in_valid & in_ready`.
- **Drain:** drain = `out_vld & ~fifo_in_stall`.
  - `fifo_in_valid` = drain, combinational from `fifo_in_stall`.
  - `fifo_in` = `out_data` always.
- **Ready:** `in_ready` = `~out_vld | drain`.
  - Depends only on `out_vld` and stall, never on `in_valid` or `in_last`.
- **Beat placement:** on accept, the beat is written to `acc[idx*BEAT_W +: BEAT_W]`; beat 0 occupies the LSBs.
- **Word completion:** on accept with `idx`==BEATS-1 or `in_last`==1:
  - the completed word (current `acc` merged with this beat; unfilled upper beats are zero) loads `out_data`;
  - `out_vld` is set;
  - `acc` is cleared to 0 and `idx` returns to 0.
- **Otherwise on accept:** `idx` increments.
- **Drain without load:** `out_vld` clears.
- **Drain and load in the same cycle:** `out_vld` stays 1 and `out_data` takes the new word.
- **Hold:** while `out_vld` is 1 and stall is 1, `out_data` holds stable and no beats are accepted.
- **`in_last` at idx 0:** emits a single-beat word with beats 1..BEATS-1 zero.
- **`words_sent`:** +1 on every drain; wraps 2^CNT_W-1 → 0.
- **`sticky_overflow`:** set the cycle after `fifo_overflow`==1; cleared only by reset.
- **`idle`** = (`idx`==0) & ~`out_vld`.

## Timing
- **Reset values:**
  - `acc`=0, `idx`=0, `out_vld`=0, `out_data`=0;
  - outputs: `in_ready`=1, `fifo_in_valid`=0, `fifo_in`=0, `words_sent`=0, `sticky_overflow`=0, `idle`=1.
- **Latency:** the word-completing beat accepted at edge N gives `fifo_in_valid`=1 in cycle N+1 if `fifo_in_stall`=0.
- **Throughput:** sustained 1 beat/cycle with stall low, i.e. one 96-bit write every BEATS cycles. No bubbles when drain and load coincide.
- **Stall:** `fifo_in_valid` never asserts while `fifo_in_stall`=1. A stall rising mid-word does not block beat acceptance until a completed word is waiting.
- **Reset mid-operation:** a partial word and a pending word are discarded; no write is issued.
- **X safety:** `in_data`/`in_last` are ignored when `in_valid`=0.

## Test plan
- **Full words:** beats 0x11111111, 0x22222222, 0x33333333 back-to-back, stall low → one write, `fifo_in`=0x333333332222222211111111, `fifo_in_valid` one cycle after the third beat, `words_sent`=1.
- **Partial flush:** 0xAAAA0001 with `in_last`=1 at idx 1 after beat 0xBBBB0000 → `fifo_in`=0x00000000AAAA0001BBBB0000.
- **Stall hold:** stall=1 before the third beat of word A, then 3 more beats offered → `in_ready`=0 after word A completes, and `fifo_in` holds A.
  - At stall release: A is written.
  - Next cycle: `in_ready`=1, and the 96-bit word later emitted is exactly the next three beats.
  - No beat lost or duplicated.
- **Streaming:** 300 beats continuous, stall toggling pseudo-randomly → 100 writes in order, `words_sent`=100, never `fifo_in_valid`&`fifo_in_stall`.
- **Overflow and wrap:** pulse `fifo_overflow` one cycle → `sticky_overflow`=1 until reset. Preload 65535 writes then one more → `words_sent`=0.
- **Reset mid-word:** reset asserted after 2 beats → no write, `idle`=1. The next 3 beats form a clean word.
